// File: rtl/ib_alu_sequencer.sv
// Two-requester round-robin sequencer for the 4-bit add/sub nibble slice.
// Runs one 4*NIB-bit add or subtract serially, LSB nibble first, with a registered carry chain.
module ib_alu_sequencer #(
    parameter int NIB = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Req0,
    input  logic               AddSub0,
    input  logic [4*NIB-1:0]   A0w,
    input  logic [4*NIB-1:0]   B0w,
    input  logic               Req1,
    input  logic               AddSub1,
    input  logic [4*NIB-1:0]   A1w,
    input  logic [4*NIB-1:0]   B1w,
    output logic               Gnt0,
    output logic               Gnt1,
    output logic               Done0,
    output logic               Done1,
    output logic [4*NIB-1:0]   Result,
    output logic               Carry,
    output logic               Zero,
    output logic               Busy
);

    localparam int W     = 4 * NIB;
    localparam int CW    = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int NSLOT = 1 << CW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_reg;
    logic [CW-1:0]  cnt_reg;
    logic           carry_reg;
    logic           rr_last_reg;
    logic           owner_reg;
    logic           op_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   work_reg;
    logic [W-1:0]   result_reg;
    logic           carry_out_reg;
    logic           zero_reg;
    logic           gnt0_reg;
    logic           gnt1_reg;
    logic           done0_reg;
    logic           done1_reg;

    logic [3:0]     a_slot [NSLOT];
    logic [3:0]     b_slot [NSLOT];
    logic [3:0]     a_nib;
    logic [3:0]     b_nib;
    logic [4:0]     sum;
    logic [W-1:0]   word_next;
    logic           last_nib;
    logic           req_any;
    logic           win1;

    // Nibble views of the latched operands; unused slots (non-power-of-2 NIB) read as zero.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NIB) begin : g_used
                assign a_slot[gi] = a_reg[4*gi +: 4];
                assign b_slot[gi] = b_reg[4*gi +: 4];
            end else begin : g_unused
                assign a_slot[gi] = 4'd0;
                assign b_slot[gi] = 4'd0;
            end
        end
    endgenerate

    assign a_nib = a_slot[cnt_reg];
    assign b_nib = b_slot[cnt_reg];
    assign sum   = {1'b0, b_nib} + {1'b0, (op_reg ? ~a_nib : a_nib)} + {4'd0, carry_reg};

    // Working word with the current nibble replaced, so the final edge can publish it whole.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_word
            assign word_next[4*gi +: 4] = (cnt_reg == CW'(gi)) ? sum[3:0] : work_reg[4*gi +: 4];
        end
    endgenerate

    assign last_nib = (cnt_reg == CW'(NIB - 1));
    assign req_any  = Req0 | Req1;
    // When both request, the one not served last wins.
    assign win1     = Req1 & (~Req0 | ~rr_last_reg);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            rr_last_reg   <= 1'b1;
            owner_reg     <= 1'b0;
            op_reg        <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            work_reg      <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            zero_reg      <= 1'b0;
            gnt0_reg      <= 1'b0;
            gnt1_reg      <= 1'b0;
            done0_reg     <= 1'b0;
            done1_reg     <= 1'b0;
        end else begin
            gnt0_reg  <= 1'b0;
            gnt1_reg  <= 1'b0;
            done0_reg <= 1'b0;
            done1_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (req_any) begin
                        owner_reg <= win1;
                        op_reg    <= win1 ? AddSub1 : AddSub0;
                        carry_reg <= win1 ? AddSub1 : AddSub0;
                        a_reg     <= win1 ? A1w : A0w;
                        b_reg     <= win1 ? B1w : B0w;
                        work_reg  <= '0;
                        cnt_reg   <= '0;
                        gnt0_reg  <= ~win1;
                        gnt1_reg  <= win1;
                        state_reg <= ST_RUN;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    work_reg  <= word_next;
                    carry_reg <= sum[4];
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_nib) begin
                        result_reg    <= word_next;
                        carry_out_reg <= sum[4];
                        zero_reg      <= (word_next == '0);
                        done0_reg     <= ~owner_reg;
                        done1_reg     <= owner_reg;
                        rr_last_reg   <= owner_reg;
                        state_reg     <= ST_DONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign Gnt0   = gnt0_reg;
    assign Gnt1   = gnt1_reg;
    assign Done0  = done0_reg;
    assign Done1  = done1_reg;
    assign Result = result_reg;
    assign Carry  = carry_out_reg;
    assign Zero   = zero_reg;
    assign Busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ib_alu_sequencer.sv
// Bench for ib_alu_sequencer: vector table, randomized ops against a word-level model,
// round-robin, mid-operation reset and a single-nibble instance.
module tb_ib_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        req0, req1, sub0, sub1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1, cy, zr, busy;
    logic [15:0] res;

    logic        p_req0, p_req1, p_sub0, p_sub1;
    logic [3:0]  p_a0, p_b0, p_a1, p_b1;
    logic        p_gnt0, p_gnt1, p_done0, p_done1, p_cy, p_zr, p_busy;
    logic [3:0]  p_res;

    int n_cmp = 0;
    int n_bad = 0;

    ib_alu_sequencer #(.NIB(4)) u_dut4 (
        .CLK(clk), .Reset(rst),
        .Req0(req0), .AddSub0(sub0), .A0w(a0), .B0w(b0),
        .Req1(req1), .AddSub1(sub1), .A1w(a1), .B1w(b1),
        .Gnt0(gnt0), .Gnt1(gnt1), .Done0(done0), .Done1(done1),
        .Result(res), .Carry(cy), .Zero(zr), .Busy(busy)
    );

    ib_alu_sequencer #(.NIB(1)) u_dut1 (
        .CLK(clk), .Reset(rst),
        .Req0(p_req0), .AddSub0(p_sub0), .A0w(p_a0), .B0w(p_b0),
        .Req1(p_req1), .AddSub1(p_sub1), .A1w(p_a1), .B1w(p_b1),
        .Gnt0(p_gnt0), .Gnt1(p_gnt1), .Done0(p_done0), .Done1(p_done1),
        .Result(p_res), .Carry(p_cy), .Zero(p_zr), .Busy(p_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sel;
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_res;
        logic        exp_c;
        logic        exp_z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Word-level reference: sub is B + ~A + 1 over W bits; carry is bit W of the sum.
    function automatic logic [32:0] ref_op(input int nib, input logic sub,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask;
        logic [63:0] aa, bb, s;
        mask = (64'd1 << (4 * nib)) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = {32'd0, b} & mask;
        s    = sub ? (bb + ((~aa) & mask) + 64'd1) : (bb + aa);
        return {s[4*nib], 32'(s & mask)};
    endfunction

    // Waits for the grant, releases the request, then checks latency, Busy, flags and hold.
    task automatic finish_op(input logic sel, input logic [15:0] er, input logic ec,
                             input logic ez, input string nm);
        bit got;
        bit early_done;
        int lat;
        int busy_n;
        got = 0;
        early_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done0 | done1) early_done = 1;
            if (gnt0 | gnt1) begin
                got = 1;
                break;
            end
        end
        check({nm, " grant_seen"}, 32'(got), 32'd1);
        check({nm, " no_done_before_grant"}, 32'(early_done), 32'd0);
        if (!got) begin
            req0 = 0;
            req1 = 0;
            return;
        end
        check({nm, " gnt0"}, 32'(gnt0), 32'(!sel));
        check({nm, " gnt1"}, 32'(gnt1), 32'(sel));
        if (sel) req1 = 0; else req0 = 0;
        got = 0;
        lat = 0;
        busy_n = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) busy_n++;
            if (lat == 1) check({nm, " gnt_one_cycle"}, 32'(gnt0 | gnt1), 32'd0);
            if (done0 | done1) begin
                got = 1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check({nm, " done_seen"}, 32'(got), 32'd1);
        check({nm, " latency"}, 32'(lat), 32'd4);
        check({nm, " busy_cycles"}, 32'(busy_n), 32'd5);
        check({nm, " done0"}, 32'(done0), 32'(!sel));
        check({nm, " done1"}, 32'(done1), 32'(sel));
        check({nm, " result"}, 32'(res), 32'(er));
        check({nm, " carry"}, 32'(cy), 32'(ec));
        check({nm, " zero"}, 32'(zr), 32'(ez));
        @(negedge clk);
        check({nm, " done_cleared"}, 32'(done0 | done1), 32'd0);
        check({nm, " idle_after"}, 32'(busy), 32'd0);
        check({nm, " result_held"}, 32'(res), 32'(er));
        $display("op %s sel=%0d result=%h carry=%0d zero=%0d", nm, sel, res, cy, zr);
    endtask

    task automatic do_op(input logic sel, input logic sub, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] er, input logic ec,
                         input logic ez, input string nm);
        if (sel) begin
            req1 = 1; sub1 = sub; a1 = a; b1 = b;
        end else begin
            req0 = 1; sub0 = sub; a0 = a; b0 = b;
        end
        finish_op(sel, er, ec, ez, nm);
    endtask

    vec_t vecs[8];

    initial begin
        logic [32:0] r;
        logic        sel, sub;
        logic [15:0] a, b;
        int          g_owner[4];
        int          g_cyc[4];
        int          exp_owner[4];
        int          ng, nd, lat;
        bit          got;

        vecs[0] = '{0, 0, 16'h1234, 16'h0FFF, 16'h2233, 0, 0};
        vecs[1] = '{1, 1, 16'h0003, 16'h0005, 16'h0002, 1, 0};
        vecs[2] = '{1, 1, 16'h0005, 16'h0003, 16'hFFFE, 0, 0};
        vecs[3] = '{0, 0, 16'h0001, 16'hFFFF, 16'h0000, 1, 1};
        vecs[4] = '{1, 1, 16'hABCD, 16'hABCD, 16'h0000, 1, 1};
        vecs[5] = '{0, 1, 16'h0000, 16'h0000, 16'h0000, 1, 1};
        vecs[6] = '{1, 0, 16'h0010, 16'h00F0, 16'h0100, 0, 0};
        vecs[7] = '{0, 0, 16'h8000, 16'h8000, 16'h0000, 1, 1};

        rst = 1;
        req0 = 0; req1 = 0; sub0 = 0; sub1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        p_req0 = 0; p_req1 = 0; p_sub0 = 0; p_sub1 = 0;
        p_a0 = 0; p_b0 = 0; p_a1 = 0; p_b1 = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("reset outputs", {gnt0, gnt1, done0, done1, cy, zr, busy}, 32'd0);
        check("reset result", 32'(res), 32'd0);
        check("reset nib1 outputs", {p_gnt0, p_gnt1, p_done0, p_done1, p_cy, p_zr, p_busy, p_res}, 32'd0);

        for (int i = 0; i < 8; i++)
            do_op(vecs[i].sel, vecs[i].sub, vecs[i].a, vecs[i].b,
                  vecs[i].exp_res, vecs[i].exp_c, vecs[i].exp_z, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            a   = 16'($urandom);
            b   = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                b = a;
                sub = 1;
            end
            r = ref_op(4, sub, {16'd0, a}, {16'd0, b});
            do_op(sel, sub, a, b, r[15:0], r[32], (r[15:0] == 16'd0), $sformatf("rnd%0d", i));
        end

        // Both requesters held from reset: alternation starting at 0, accepts 5 cycles apart.
        rst = 1;
        @(negedge clk);
        rst = 0;
        req0 = 1; sub0 = 0; a0 = 16'h0101; b0 = 16'h2020;
        req1 = 1; sub1 = 1; a1 = 16'h0001; b1 = 16'h1000;
        exp_owner = '{0, 1, 0, 1};
        ng = 0;
        nd = 0;
        for (int k = 0; k < 60 && nd < 4; k++) begin
            @(negedge clk);
            if (gnt0 | gnt1) begin
                if (ng < 4) begin
                    g_owner[ng] = int'(gnt1);
                    g_cyc[ng] = k;
                end
                ng++;
                if (ng == 4) begin
                    req0 = 0;
                    req1 = 0;
                end
            end
            if ((done0 | done1) && nd < ng && nd < 4) begin
                check($sformatf("rr done%0d owner", nd), 32'(done1), 32'(g_owner[nd]));
                r = ref_op(4, g_owner[nd] != 0, g_owner[nd] != 0 ? 32'h0001 : 32'h0101,
                           g_owner[nd] != 0 ? 32'h1000 : 32'h2020);
                check($sformatf("rr done%0d result", nd), 32'(res), 32'(r[15:0]));
                check($sformatf("rr done%0d carry", nd), 32'(cy), 32'(r[32]));
                $display("rr done %0d owner=%0d result=%h", nd, int'(done1), res);
                nd++;
            end
        end
        req0 = 0;
        req1 = 0;
        check("rr grants", 32'(ng), 32'd4);
        check("rr dones", 32'(nd), 32'd4);
        for (int i = 0; i < 4 && i < ng; i++) begin
            check($sformatf("rr grant%0d owner", i), 32'(g_owner[i]), 32'(exp_owner[i]));
            if (i > 0) check($sformatf("rr grant%0d spacing", i), 32'(g_cyc[i] - g_cyc[i-1]), 32'd5);
        end
        repeat (2) @(negedge clk);
        check("rr idle", 32'(busy), 32'd0);

        // Reset two cycles into RUN: outputs clear at once, no Done, clean restart.
        do_op(0, 0, 16'h1234, 16'h0FFF, 16'h2233, 0, 0, "pre_reset");
        req0 = 1; sub0 = 0; a0 = 16'h1111; b0 = 16'h2222;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt0) begin
                got = 1;
                break;
            end
        end
        check("abort grant_seen", 32'(got), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1;
        #1;
        check("async reset outputs", {gnt0, gnt1, done0, done1, cy, zr, busy}, 32'd0);
        check("async reset result", 32'(res), 32'd0);
        @(negedge clk);
        check("reset held no done", 32'(done0 | done1), 32'd0);
        rst = 0;
        finish_op(0, 16'h3333, 0, 0, "restart");

        // Single-nibble instance: Done one edge after accept.
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                sub = 0; a = 16'h8; b = 16'h9;
            end else begin
                sub = 1'($urandom_range(0, 1));
                a = 16'($urandom_range(0, 15));
                b = 16'($urandom_range(0, 15));
            end
            r = ref_op(1, sub, {16'd0, a}, {16'd0, b});
            p_req0 = 1; p_sub0 = sub; p_a0 = a[3:0]; p_b0 = b[3:0];
            got = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (p_gnt0) begin
                    got = 1;
                    break;
                end
            end
            check($sformatf("nib1 op%0d grant", i), 32'(got), 32'd1);
            p_req0 = 0;
            lat = 0;
            got = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                lat++;
                if (p_done0) begin
                    got = 1;
                    break;
                end
            end
            check($sformatf("nib1 op%0d done", i), 32'(got), 32'd1);
            check($sformatf("nib1 op%0d latency", i), 32'(lat), 32'd1);
            check($sformatf("nib1 op%0d result", i), 32'(p_res), 32'(r[3:0]));
            check($sformatf("nib1 op%0d carry", i), 32'(p_cy), 32'(r[32]));
            check($sformatf("nib1 op%0d zero", i), 32'(p_zr), 32'(r[3:0] == 4'd0));
            $display("nib1 op%0d b=%h a=%h sub=%0d result=%h carry=%0d", i, b[3:0], a[3:0], sub, p_res, p_cy);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
